// File: rtl/silent_pkg.sv
// Shared constants and FSM state type for the silent_seq channel sweeper.
package silent_pkg;

   localparam int unsigned DEFAULT_WIDTH   = 13;
   localparam int unsigned DEFAULT_DEPTH   = 249;
   localparam int unsigned DEFAULT_LATENCY = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/silent_addr_delay.sv
// Fixed-depth valid/address delay line that aligns write-back with the
// external datapath's read-to-result latency.
module silent_addr_delay #(
   parameter int unsigned ADDR_W  = 8,
   parameter int unsigned LATENCY = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid,
   input  logic [ADDR_W-1:0] addr,
   output logic              dly_valid,
   output logic [ADDR_W-1:0] dly_addr
);

   logic              vld_q  [LATENCY];
   logic [ADDR_W-1:0] addr_q [LATENCY];

   // Shift valid and address one stage per cycle; reset flushes every stage.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < LATENCY; i++) begin
            vld_q[i]  <= 1'b0;
            addr_q[i] <= '0;
         end
      end else begin
         vld_q[0]  <= valid;
         addr_q[0] <= addr;
         for (int unsigned i = 1; i < LATENCY; i++) begin
            vld_q[i]  <= vld_q[i-1];
            addr_q[i] <= addr_q[i-1];
         end
      end
   end

   // Last stage is the delayed write-back strobe and index.
   always_comb begin
      dly_valid = vld_q[LATENCY-1];
      dly_addr  = addr_q[LATENCY-1];
   end

endmodule

// File: rtl/silent_seq.sv
// Per-update channel sweeper: reads DEPTH channels, issues LATENCY-delayed
// write-backs, then pulses OUT_VALID. UPDATEs arriving while busy are
// dropped and flagged on the sticky OVERRUN output.
module silent_seq
   import silent_pkg::*;
#(
   parameter  int unsigned WIDTH   = DEFAULT_WIDTH,
   parameter  int unsigned DEPTH   = DEFAULT_DEPTH,
   parameter  int unsigned LATENCY = DEFAULT_LATENCY,
   localparam int unsigned ADDR_W  = $clog2(DEPTH)
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              UPDATE,
   input  logic              ENABLE,
   input  logic [WIDTH-1:0]  STEP,
   output logic [ADDR_W-1:0] RD_ADDR,
   output logic              RD_EN,
   output logic [WIDTH-1:0]  STEP_L,
   output logic              BYPASS,
   output logic [ADDR_W-1:0] WR_ADDR,
   output logic              WR_EN,
   output logic              OUT_VALID,
   output logic              BUSY,
   output logic              OVERRUN
);

   state_t            state;
   logic [ADDR_W-1:0] addr_cnt;
   logic              last_rd;
   logic              last_wr;
   logic              wr_en_d;
   logic [ADDR_W-1:0] wr_addr_d;

   // Terminal-count decodes for the read sweep and the final write-back.
   always_comb begin
      last_rd = (addr_cnt == ADDR_W'(DEPTH - 1));
      last_wr = wr_en_d && (wr_addr_d == ADDR_W'(DEPTH - 1));
   end

   // Sweep FSM, address counter, per-sweep latches and sticky overrun flag.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= IDLE;
         addr_cnt <= '0;
         STEP_L   <= '0;
         BYPASS   <= 1'b0;
         OVERRUN  <= 1'b0;
      end else begin
         if (UPDATE && (state != IDLE)) begin
            OVERRUN <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (UPDATE) begin
                  state    <= RUN;
                  addr_cnt <= '0;
                  STEP_L   <= (STEP == '0) ? WIDTH'(1) : STEP;
                  BYPASS   <= ~ENABLE;
               end
            end
            RUN: begin
               // Counter parks at DEPTH-1 rather than wrapping.
               if (last_rd) begin
                  state <= DRAIN;
               end else begin
                  addr_cnt <= addr_cnt + ADDR_W'(1);
               end
            end
            DRAIN: begin
               if (last_wr) begin
                  state <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Read-side and status outputs decoded from registered state.
   always_comb begin
      RD_EN     = (state == RUN);
      RD_ADDR   = addr_cnt;
      BUSY      = (state != IDLE);
      OUT_VALID = (state == DONE);
      WR_EN     = wr_en_d;
      WR_ADDR   = wr_addr_d;
   end

   silent_addr_delay #(
      .ADDR_W  (ADDR_W),
      .LATENCY (LATENCY)
   ) u_delay (
      .clk       (CLK),
      .rst       (RST),
      .valid     (RD_EN),
      .addr      (RD_ADDR),
      .dly_valid (wr_en_d),
      .dly_addr  (wr_addr_d)
   );

endmodule

// File: tb/tb_silent_seq.sv
// Directed bench for silent_seq: default build (DEPTH=249, LATENCY=3) and a
// small build (DEPTH=4, LATENCY=1) sharing clock, reset, STEP and ENABLE.
module tb_silent_seq;

   logic        clk;
   logic        rst;
   logic        upd;
   logic        en;
   logic [12:0] step;
   logic        sel_b;

   logic        a_upd, b_upd;

   logic [7:0]  a_rd_addr, a_wr_addr;
   logic        a_rd_en, a_wr_en, a_bypass, a_out_valid, a_busy, a_overrun;
   logic [12:0] a_step_l;

   logic [1:0]  b_rd_addr, b_wr_addr;
   logic        b_rd_en, b_wr_en, b_bypass, b_out_valid, b_busy, b_overrun;
   logic [12:0] b_step_l;

   logic [31:0] o_rd_addr, o_wr_addr, o_rd_en, o_wr_en, o_bypass;
   logic [31:0] o_out_valid, o_busy, o_overrun, o_step_l;

   int tests;
   int fails;
   int exp_ovr;

   assign a_upd = upd && !sel_b;
   assign b_upd = upd && sel_b;

   assign o_rd_addr   = sel_b ? 32'(b_rd_addr)   : 32'(a_rd_addr);
   assign o_wr_addr   = sel_b ? 32'(b_wr_addr)   : 32'(a_wr_addr);
   assign o_rd_en     = sel_b ? 32'(b_rd_en)     : 32'(a_rd_en);
   assign o_wr_en     = sel_b ? 32'(b_wr_en)     : 32'(a_wr_en);
   assign o_bypass    = sel_b ? 32'(b_bypass)    : 32'(a_bypass);
   assign o_out_valid = sel_b ? 32'(b_out_valid) : 32'(a_out_valid);
   assign o_busy      = sel_b ? 32'(b_busy)      : 32'(a_busy);
   assign o_overrun   = sel_b ? 32'(b_overrun)   : 32'(a_overrun);
   assign o_step_l    = sel_b ? 32'(b_step_l)    : 32'(a_step_l);

   silent_seq u_a (
      .CLK       (clk),
      .RST       (rst),
      .UPDATE    (a_upd),
      .ENABLE    (en),
      .STEP      (step),
      .RD_ADDR   (a_rd_addr),
      .RD_EN     (a_rd_en),
      .STEP_L    (a_step_l),
      .BYPASS    (a_bypass),
      .WR_ADDR   (a_wr_addr),
      .WR_EN     (a_wr_en),
      .OUT_VALID (a_out_valid),
      .BUSY      (a_busy),
      .OVERRUN   (a_overrun)
   );

   silent_seq #(
      .DEPTH   (4),
      .LATENCY (1)
   ) u_b (
      .CLK       (clk),
      .RST       (rst),
      .UPDATE    (b_upd),
      .ENABLE    (en),
      .STEP      (step),
      .RD_ADDR   (b_rd_addr),
      .RD_EN     (b_rd_en),
      .STEP_L    (b_step_l),
      .BYPASS    (b_bypass),
      .WR_ADDR   (b_wr_addr),
      .WR_EN     (b_wr_en),
      .OUT_VALID (b_out_valid),
      .BUSY      (b_busy),
      .OVERRUN   (b_overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_reset();
      chk("rst_busy",      o_busy,      0);
      chk("rst_rd_en",     o_rd_en,     0);
      chk("rst_wr_en",     o_wr_en,     0);
      chk("rst_out_valid", o_out_valid, 0);
      chk("rst_overrun",   o_overrun,   0);
      chk("rst_rd_addr",   o_rd_addr,   0);
      chk("rst_wr_addr",   o_wr_addr,   0);
      chk("rst_step_l",    o_step_l,    0);
      chk("rst_bypass",    o_bypass,    0);
   endtask

   // k = 1 is the first RUN cycle after the accepting edge; OUT_VALID is
   // expected at k = d+l+1. Event offsets of 0 mean "none".
   task automatic sweep(input int d, input int l, input int ovr_k, input int chg_k,
                        input int rst_k, input int exp_step, input int exp_byp);
      int n;
      n = d + l + 1;
      upd = 1'b1;
      tick();
      upd = 1'b0;
      for (int k = 1; k <= n; k++) begin
         chk("rd_en", o_rd_en, (k <= d) ? 1 : 0);
         if (k <= d) chk("rd_addr", o_rd_addr, k - 1);
         chk("wr_en", o_wr_en, (k > l && k <= d + l) ? 1 : 0);
         if (k > l && k <= d + l) chk("wr_addr", o_wr_addr, k - 1 - l);
         chk("out_valid", o_out_valid, (k == n) ? 1 : 0);
         chk("busy", o_busy, 1);
         chk("step_l", o_step_l, exp_step);
         chk("bypass", o_bypass, exp_byp);
         chk("overrun", o_overrun, exp_ovr);
         if (k == chg_k) step = 13'd40;
         if (k == rst_k) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
            exp_ovr = 0;
            for (int j = 0; j < n + 4; j++) begin
               chk("abort_busy",      o_busy,      0);
               chk("abort_wr_en",     o_wr_en,     0);
               chk("abort_out_valid", o_out_valid, 0);
               tick();
            end
            return;
         end
         upd = (k == ovr_k) ? 1'b1 : 1'b0;
         tick();
         if (k == ovr_k) exp_ovr = 1;
         upd = 1'b0;
      end
      chk("idle_busy",      o_busy,      0);
      chk("idle_out_valid", o_out_valid, 0);
      chk("idle_overrun",   o_overrun,   exp_ovr);
   endtask

   initial begin
      tests   = 0;
      fails   = 0;
      exp_ovr = 0;
      rst     = 1'b1;
      upd     = 1'b0;
      en      = 1'b1;
      step    = 13'd16;
      sel_b   = 1'b0;
      tick();
      tick();
      chk_reset();
      sel_b = 1'b1;
      #1;
      chk_reset();
      sel_b = 1'b0;
      #1;
      rst = 1'b0;

      // Idle lead-in up to the first UPDATE (sampled at the end of cycle 10).
      for (int i = 1; i < 10; i++) begin
         tick();
         chk("lead_busy", o_busy, 0);
      end

      // Nominal filtered sweep, STEP=16.
      sweep(249, 3, 0, 0, 0, 16, 0);

      // Dropped UPDATE 90 cycles into the sweep; timing unchanged.
      sweep(249, 3, 90, 0, 0, 16, 0);

      // STEP=0 latches as 1, bypass sweep; STEP change mid-sweep ignored.
      step = 13'd0;
      en   = 1'b0;
      sweep(249, 3, 0, 50, 0, 1, 1);

      // Reset 140 cycles into a sweep aborts it; a fresh sweep follows.
      step = 13'd7;
      en   = 1'b1;
      sweep(249, 3, 0, 0, 140, 7, 0);
      chk_reset();
      step = 13'd5;
      en   = 1'b0;
      sweep(249, 3, 0, 0, 0, 5, 1);

      // Small build: back-to-back sweeps without overrun.
      sel_b = 1'b1;
      rst   = 1'b1;
      tick();
      rst   = 1'b0;
      exp_ovr = 0;
      chk_reset();
      step = 13'd9;
      en   = 1'b1;
      sweep(4, 1, 0, 0, 0, 9, 0);
      sweep(4, 1, 0, 0, 0, 9, 0);
      chk("b2b_overrun", o_overrun, 0);

      // UPDATE coincident with DONE is dropped and flags overrun.
      sweep(4, 1, 6, 0, 0, 9, 0);
      chk("done_upd_busy", o_busy, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
